// File: rtl/io_store_rmw_sequencer_pkg.sv
// Shared IO definitions: store-size encoding, sequencer state enum and a
// helper that turns a size code into a byte count.
package io_store_rmw_sequencer_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_WORD   = 2'b01,
    SIZE_DOUBLE = 2'b10,
    SIZE_QUAD   = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MERGE = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Number of bytes moved by a store of the given size code.
  function automatic int unsigned size_bytes(input store_size_e sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/io_store_rmw_sequencer_if.sv
// Store request and port-buffer bus of the RMW sequencer.
// Handshake: a request transfers on a rising clk edge where StoreReqValid and
// StoreReqReady are both high and clk_en is high; the master holds the request
// fields stable while StoreReqValid is high and not yet accepted.
interface io_store_rmw_sequencer_if #(
  parameter int DATABITWIDTH        = 16,
  parameter int PORTBYTEWIDTH       = 16,
  parameter int BUFFERINDEXBITWIDTH = 3
);
  logic                           StoreReqValid;
  logic                           StoreReqReady;
  logic [3:0]                     MinorOpcodeIn;
  logic [DATABITWIDTH-1:0]        DataAddrIn;
  logic [DATABITWIDTH-1:0]        DataIn;
  logic                           BufferReadEn;
  logic [BUFFERINDEXBITWIDTH-1:0] BufferReadIndex;
  logic [DATABITWIDTH-1:0]        BufferReadData;
  logic                           BufferWriteEn;
  logic [BUFFERINDEXBITWIDTH-1:0] BufferWriteIndex;
  logic [DATABITWIDTH-1:0]        BufferWriteData;
  logic [PORTBYTEWIDTH-1:0]       BufferByteEn;
  logic                           StoreDone;
  logic                           StoreError;

  // Requester and port buffer side.
  modport master (
    output StoreReqValid, MinorOpcodeIn, DataAddrIn, DataIn, BufferReadData,
    input  StoreReqReady, BufferReadEn, BufferReadIndex, BufferWriteEn,
           BufferWriteIndex, BufferWriteData, BufferByteEn, StoreDone, StoreError
  );

  // Sequencer side.
  modport slave (
    input  StoreReqValid, MinorOpcodeIn, DataAddrIn, DataIn, BufferReadData,
    output StoreReqReady, BufferReadEn, BufferReadIndex, BufferWriteEn,
           BufferWriteIndex, BufferWriteData, BufferByteEn, StoreDone, StoreError
  );
endinterface

// File: rtl/io_store_rmw_sequencer_merge.sv
// Combinational byte-lane merge of store data into an element word, plus the
// port-wide byte-enable mask. Bytes that would fall outside the addressed
// element (or past the end of the port) are dropped rather than wrapped.
module io_store_merge
  import io_store_rmw_sequencer_pkg::*;
#(
  parameter int DATABITWIDTH  = 16,
  parameter int PORTBYTEWIDTH = 16,
  parameter int PORTOFFBITS   = ($clog2(PORTBYTEWIDTH) > 1) ? $clog2(PORTBYTEWIDTH) : 1
) (
  input  logic [DATABITWIDTH-1:0]  i_old_word,
  input  logic [DATABITWIDTH-1:0]  i_store_data,
  input  logic [PORTOFFBITS-1:0]   i_port_off,
  input  store_size_e              i_size,
  output logic [DATABITWIDTH-1:0]  o_merged,
  output logic [PORTBYTEWIDTH-1:0] o_byte_en
);
  localparam int ELEMBYTES = DATABITWIDTH / 8;

  // Place store bytes at the lane offset and build the clipped byte mask.
  always_comb begin
    int nbytes;
    int a;
    int lane_off;
    int base;
    int k;
    nbytes   = int'(size_bytes(i_size));
    a        = int'(i_port_off);
    lane_off = a % ELEMBYTES;
    base     = a - lane_off;
    o_merged = i_old_word;
    for (int j = 0; j < ELEMBYTES; j++) begin
      k = j - lane_off;
      if (k >= 0 && k < nbytes) o_merged[8*j +: 8] = i_store_data[8*k +: 8];
    end
    o_byte_en = '0;
    for (int p = 0; p < PORTBYTEWIDTH; p++) begin
      o_byte_en[p] = (p >= a) && (p < a + nbytes) && (p < base + ELEMBYTES);
    end
  end
endmodule

// File: rtl/io_store_rmw_sequencer.sv
// Store read-modify-write sequencer: partial-width stores read the element,
// merge the new bytes and write it back; full-width stores write directly;
// over-wide stores are rejected with a one-cycle error pulse.
module io_store_rmw_sequencer
  import io_store_rmw_sequencer_pkg::*;
#(
  parameter int DATABITWIDTH        = 16,
  parameter int PORTBYTEWIDTH       = 16,
  parameter int BUFFERCOUNT         = ((PORTBYTEWIDTH * 8 / DATABITWIDTH) > 1) ?
                                      (PORTBYTEWIDTH * 8 / DATABITWIDTH) : 1,
  parameter int BUFFERINDEXBITWIDTH = ($clog2(BUFFERCOUNT) > 1) ? $clog2(BUFFERCOUNT) : 1
) (
  input  logic                    clk,
  input  logic                    async_rst_n,
  input  logic                    clk_en,
  io_store_rmw_sequencer_if.slave bus,
  output state_e                  o_dbg_state
);
  localparam int          DATAINDEX   = ($clog2(DATABITWIDTH / 8) > 1) ? $clog2(DATABITWIDTH / 8) : 1;
  localparam int          PORTOFFBITS = ($clog2(PORTBYTEWIDTH) > 1) ? $clog2(PORTBYTEWIDTH) : 1;
  localparam int unsigned ELEMBYTES   = DATABITWIDTH / 8;

  state_e                         r_state;
  store_size_e                    r_size;
  logic [PORTOFFBITS-1:0]         r_port_off;
  logic [DATABITWIDTH-1:0]        r_data;
  logic [BUFFERINDEXBITWIDTH-1:0] r_index;
  logic                           r_read_en;
  logic [BUFFERINDEXBITWIDTH-1:0] r_read_index;
  logic                           r_write_en;
  logic [BUFFERINDEXBITWIDTH-1:0] r_write_index;
  logic [DATABITWIDTH-1:0]        r_write_data;
  logic [PORTBYTEWIDTH-1:0]       r_byte_en;
  logic                           r_done;
  logic                           r_error;

  store_size_e                    w_req_size;
  int unsigned                    w_req_bytes;
  logic [BUFFERINDEXBITWIDTH-1:0] w_req_index;
  store_size_e                    w_sel_size;
  logic [PORTOFFBITS-1:0]         w_sel_off;
  logic [DATABITWIDTH-1:0]        w_sel_data;
  logic [DATABITWIDTH-1:0]        w_merged;
  logic [PORTBYTEWIDTH-1:0]       w_byte_en;

  assign w_req_size  = store_size_e'(bus.MinorOpcodeIn[1:0]);
  assign w_req_bytes = size_bytes(w_req_size);
  assign w_req_index = bus.DataAddrIn[DATAINDEX +: BUFFERINDEXBITWIDTH];

  // In IDLE the merger sees the incoming request (full-width byte enables are
  // needed at accept time); afterwards it works on the latched request.
  assign w_sel_size = (r_state == ST_IDLE) ? w_req_size : r_size;
  assign w_sel_off  = (r_state == ST_IDLE) ? bus.DataAddrIn[PORTOFFBITS-1:0] : r_port_off;
  assign w_sel_data = (r_state == ST_IDLE) ? bus.DataIn : r_data;

  io_store_merge #(
    .DATABITWIDTH (DATABITWIDTH),
    .PORTBYTEWIDTH(PORTBYTEWIDTH),
    .PORTOFFBITS  (PORTOFFBITS)
  ) u_merge (
    .i_old_word  (bus.BufferReadData),
    .i_store_data(w_sel_data),
    .i_port_off  (w_sel_off),
    .i_size      (w_sel_size),
    .o_merged    (w_merged),
    .o_byte_en   (w_byte_en)
  );

  // Sequencer FSM with registered strobes; clk_en low freezes everything.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state       <= ST_IDLE;
      r_size        <= SIZE_BYTE;
      r_port_off    <= '0;
      r_data        <= '0;
      r_index       <= '0;
      r_read_en     <= 1'b0;
      r_read_index  <= '0;
      r_write_en    <= 1'b0;
      r_write_index <= '0;
      r_write_data  <= '0;
      r_byte_en     <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else if (clk_en) begin
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.StoreReqValid) begin
            r_size     <= w_req_size;
            r_port_off <= bus.DataAddrIn[PORTOFFBITS-1:0];
            r_data     <= bus.DataIn;
            r_index    <= w_req_index;
            if (w_req_bytes < ELEMBYTES) begin
              r_read_en    <= 1'b1;
              r_read_index <= w_req_index;
              r_state      <= ST_READ;
            end else if (w_req_bytes == ELEMBYTES) begin
              r_write_en    <= 1'b1;
              r_done        <= 1'b1;
              r_write_index <= w_req_index;
              r_write_data  <= bus.DataIn;
              r_byte_en     <= w_byte_en;
              r_state       <= ST_WRITE;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ST_READ: r_state <= ST_MERGE;
        ST_MERGE: begin
          r_write_en    <= 1'b1;
          r_done        <= 1'b1;
          r_write_index <= r_index;
          r_write_data  <= w_merged;
          r_byte_en     <= w_byte_en;
          r_state       <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.StoreReqReady    = (r_state == ST_IDLE);
  assign bus.BufferReadEn     = r_read_en;
  assign bus.BufferReadIndex  = r_read_index;
  assign bus.BufferWriteEn    = r_write_en;
  assign bus.BufferWriteIndex = r_write_index;
  assign bus.BufferWriteData  = r_write_data;
  assign bus.BufferByteEn     = r_byte_en;
  assign bus.StoreDone        = r_done;
  assign bus.StoreError       = r_error;
  assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_io_store_rmw_sequencer.sv
// Directed bench for io_store_rmw_sequencer (16-bit data, 16-byte port).
module tb_io_store_rmw_sequencer;
  import io_store_rmw_sequencer_pkg::*;

  localparam int DW  = 16;
  localparam int PBW = 16;
  localparam int BIW = 3;
  localparam int W   = BIW + DW + PBW;

  // ---------------- clock / reset ----------------
  logic clk         = 1'b0;
  logic async_rst_n = 1'b0;
  logic clk_en      = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  io_store_rmw_sequencer_if #(.DATABITWIDTH(DW), .PORTBYTEWIDTH(PBW),
                              .BUFFERINDEXBITWIDTH(BIW)) bus ();
  state_e dbg_state;

  io_store_rmw_sequencer #(.DATABITWIDTH(DW), .PORTBYTEWIDTH(PBW)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .clk_en     (clk_en),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // Port buffer model: read data appears the cycle after a read strobe.
  logic [DW-1:0] mem [8];
  always @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) bus.BufferReadData <= '0;
    else if (clk_en && bus.BufferReadEn) bus.BufferReadData <= mem[bus.BufferReadIndex];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]   exp_wr_q[$];
  int             exp_wr_cyc_q[$];
  logic [BIW-1:0] exp_rd_q[$];
  int             exp_err_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor: a strobe counts once, on the edge where clk_en lets it through.
  always @(negedge clk) begin
    if (async_rst_n && clk_en) begin
      if (bus.BufferWriteEn) begin
        if (exp_wr_q.size() == 0) unexpected("write");
        else begin
          logic [W-1:0] e;
          int c;
          e = exp_wr_q.pop_front();
          c = exp_wr_cyc_q.pop_front();
          check("wr_index", bus.BufferWriteIndex, e[W-1 -: BIW]);
          check("wr_data", bus.BufferWriteData, e[PBW +: DW]);
          check("wr_byte_en", bus.BufferByteEn, e[PBW-1:0]);
          check("wr_done", bus.StoreDone, 1'b1);
          if (c >= 0) check("wr_latency", cyc, c);
        end
      end else if (bus.StoreDone) unexpected("done_without_write");
      if (bus.BufferReadEn) begin
        if (exp_rd_q.size() == 0) unexpected("read");
        else check("rd_index", bus.BufferReadIndex, exp_rd_q.pop_front());
      end
      if (bus.StoreError) begin
        if (exp_err_cyc_q.size() == 0) unexpected("error");
        else check("err_latency", cyc, exp_err_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [15:0] addr,
                       input logic [15:0] data, output int acc);
    int t;
    @(posedge clk); #1;
    bus.StoreReqValid = 1'b1;
    bus.MinorOpcodeIn = op;
    bus.DataAddrIn    = addr;
    bus.DataIn        = data;
    t = 0;
    while (!bus.StoreReqReady && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) unexpected("ready_timeout");
    @(posedge clk); #1;
    acc = cyc;
    bus.StoreReqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (t < 50 && !(dbg_state == ST_IDLE && exp_wr_q.size() == 0 &&
                           exp_rd_q.size() == 0 && exp_err_cyc_q.size() == 0));
    if (t == 50) unexpected("idle_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.StoreReqReady, 1'b1);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    check({tag, "_rd_en"}, bus.BufferReadEn, 1'b0);
    check({tag, "_rd_idx"}, bus.BufferReadIndex, '0);
    check({tag, "_wr_en"}, bus.BufferWriteEn, 1'b0);
    check({tag, "_wr_idx"}, bus.BufferWriteIndex, '0);
    check({tag, "_wr_data"}, bus.BufferWriteData, '0);
    check({tag, "_byte_en"}, bus.BufferByteEn, '0);
    check({tag, "_done"}, bus.StoreDone, 1'b0);
    check({tag, "_error"}, bus.StoreError, 1'b0);
  endtask

  function automatic logic [W-1:0] wr(input logic [BIW-1:0] idx,
                                      input logic [DW-1:0] d, input logic [PBW-1:0] be);
    return {idx, d, be};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int a;
    for (int i = 0; i < 8; i++) mem[i] = 16'h1111 * i[15:0];
    mem[1] = 16'h9ABC;
    mem[2] = 16'h1234;
    mem[5] = 16'h5A5A;
    mem[7] = 16'hC3D4;
    bus.StoreReqValid = 1'b0;
    bus.MinorOpcodeIn = '0;
    bus.DataAddrIn    = '0;
    bus.DataIn        = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 async_rst_n = 1'b1;

    // Byte store into element 2 (0x1234), upper lane.
    issue(4'b0000, 16'h0005, 16'h00AB, a);
    exp_rd_q.push_back(3'd2);
    exp_wr_q.push_back(wr(3'd2, 16'hAB34, 16'h0020)); exp_wr_cyc_q.push_back(a + 2);
    wait_idle();

    // Aligned word store: direct write.
    issue(4'b0001, 16'h0006, 16'hBEEF, a);
    exp_wr_q.push_back(wr(3'd3, 16'hBEEF, 16'h00C0)); exp_wr_cyc_q.push_back(a);
    wait_idle();

    // Double store is rejected; ready is back the following cycle.
    issue(4'b0010, 16'h0000, 16'h1111, a);
    exp_err_cyc_q.push_back(a);
    @(negedge clk);
    check("err_ready_back", bus.StoreReqReady, 1'b1);
    wait_idle();

    // Byte store, lower lane, opcode upper bits and DataIn upper byte ignored.
    issue(4'b0100, 16'h000A, 16'hFFCD, a);
    exp_rd_q.push_back(3'd5);
    exp_wr_q.push_back(wr(3'd5, 16'h5ACD, 16'h0400)); exp_wr_cyc_q.push_back(a + 2);
    wait_idle();

    // Quad store with junk upper opcode bits: rejected.
    issue(4'b1111, 16'h0002, 16'h2222, a);
    exp_err_cyc_q.push_back(a);
    wait_idle();

    // Byte store with a 4-cycle stall in MERGE.
    issue(4'b0000, 16'h0003, 16'h0077, a);
    exp_rd_q.push_back(3'd1);
    exp_wr_q.push_back(wr(3'd1, 16'h77BC, 16'h0008)); exp_wr_cyc_q.push_back(-1);
    @(posedge clk); #1;
    check("stall_enter_merge", dbg_state, ST_MERGE);
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_merge_state", dbg_state, ST_MERGE);
      check("stall_merge_wr_en", bus.BufferWriteEn, 1'b0);
      check("stall_merge_ready", bus.StoreReqReady, 1'b0);
    end
    @(posedge clk); #1 clk_en = 1'b1;
    wait_idle();

    // Word store with a stall in WRITE: strobes stretch, one write counted.
    issue(4'b0001, 16'h0000, 16'h4321, a);
    exp_wr_q.push_back(wr(3'd0, 16'h4321, 16'h0003)); exp_wr_cyc_q.push_back(-1);
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_write_wr_en", bus.BufferWriteEn, 1'b1);
      check("stall_write_done", bus.StoreDone, 1'b1);
    end
    @(posedge clk); #1 clk_en = 1'b1;
    wait_idle();

    // Reset while in READ abandons the store.
    issue(4'b0000, 16'h0005, 16'h00AB, a);
    check("pre_reset_state", dbg_state, ST_READ);
    async_rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1 async_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("post_reset_ready", bus.StoreReqReady, 1'b1);

    issue(4'b0000, 16'h000E, 16'h0011, a);
    exp_rd_q.push_back(3'd7);
    exp_wr_q.push_back(wr(3'd7, 16'hC311, 16'h4000)); exp_wr_cyc_q.push_back(a + 2);
    wait_idle();

    // Word store crossing the port end: only byte 15 enabled.
    issue(4'b0001, 16'h000F, 16'h1357, a);
    exp_wr_q.push_back(wr(3'd7, 16'h1357, 16'h8000)); exp_wr_cyc_q.push_back(a);
    wait_idle();

    repeat (3) @(negedge clk);
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("rd_q_drained", exp_rd_q.size(), 0);
    check("err_q_drained", exp_err_cyc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
